// File: rtl/prog_loader.sv
// Byte-serial program loader: framed stream (count, big-endian words, XOR checksum)
// into single-cycle instruction RAM writes, holding the CPU for the whole load.
module prog_loader #(
   parameter int RAM_SIZE  = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   output logic        mem_w,
   output logic [7:0]  mem_addr,
   output logic [31:0] mem_w_word,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERROR} state_t;

   state_t      state;
   logic [1:0]  byte_idx;
   logic [7:0]  word_idx;
   logic [7:0]  word_cnt;
   logic [7:0]  acc;
   logic [23:0] asm_reg;
   logic        take;
   logic [8:0]  addr_sum;
   logic [8:0]  addr_mod;

   assign take     = in_valid & in_ready;
   assign addr_sum = 9'(BASE_ADDR) + {1'b0, word_idx};
   assign addr_mod = addr_sum % 9'(RAM_SIZE);

   // Covers the trailing write pulse of the last word, which may outlive busy.
   assign cpu_hold = busy | mem_w;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         byte_idx   <= '0;
         word_idx   <= '0;
         word_cnt   <= '0;
         acc        <= '0;
         asm_reg    <= '0;
         in_ready   <= 1'b0;
         mem_w      <= 1'b0;
         mem_addr   <= '0;
         mem_w_word <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         mem_w <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state    <= COUNT;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  byte_idx <= '0;
                  word_idx <= '0;
                  acc      <= '0;
               end
            end
            COUNT: begin
               if (take) begin
                  acc      <= in_byte;
                  word_cnt <= in_byte;
                  if ({1'b0, in_byte} > 9'(RAM_SIZE)) begin
                     state    <= ERROR;
                     error    <= 1'b1;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                  end else if (in_byte == 8'd0) begin
                     state <= CHECK;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (take) begin
                  acc      <= acc ^ in_byte;
                  asm_reg  <= {asm_reg[15:0], in_byte};
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     mem_w      <= 1'b1;
                     mem_addr   <= addr_mod[7:0];
                     mem_w_word <= {asm_reg, in_byte};
                     word_idx   <= word_idx + 8'd1;
                     if (word_idx == word_cnt - 8'd1)
                        state <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (take) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (in_byte == acc) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ERROR;
                     error <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-serial program loader that writes 32-bit instruction words into the CPU's instruction RAM, the RAM the CPU fetch path reads instructions from. It accepts a framed byte stream (word count, big-endian instruction bytes, XOR checksum) over a valid/ready handshake and assembles each group of four bytes into one instruction word. It issues one single-cycle RAM write per word and holds the CPU for the whole load. It sits between a host link (UART receiver or testbench) and the RAM write port; the CPU's RAM read side is unchanged.

## Interface
- RAM_SIZE, 256: number of 32-bit words in RAM; legal range 1..256.
- BASE_ADDR, 0: word address of the first loaded instruction.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; all state and outputs go to reset values immediately.
- start  in  1  single-cycle request to begin a load; ignored unless the block is in IDLE, DONE or ERROR.
- in_valid  in  1  host has a byte on in_byte.
- in_byte  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both high.
- mem_w  out  1  RAM write strobe, one cycle per word.
- mem_addr  out  8  word address, valid while mem_w is high.
- mem_w_word  out  32  instruction word, valid while mem_w is high.
- cpu_hold  out  1  CPU must not fetch or execute while this is high.
- busy  out  1  high in COUNT, DATA and CHECK.
- done  out  1  load completed and checksum matched; level.
- error  out  1  load aborted; level.

## Operation
- States: IDLE, COUNT, DATA, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start: go to COUNT; clear done, error, the byte index, the word index and the checksum accumulator.
- COUNT: the first accepted byte is N, the word count.
  - The accumulator is set to N.
  - N > RAM_SIZE: go to ERROR.
  - N = 0: go to CHECK.
  - Otherwise: go to DATA.
- DATA: accepted bytes are shifted into a 32-bit assembly register, MSB first. Byte 0 lands in bits [31:24] (condition and supergroup fields); byte 3 lands in bits [7:0] (arg2).
  - Every accepted byte is XORed into the accumulator.
  - On the 4th byte of a word, the word is committed for writing and the word index increments.
  - After word N-1 commits, go to CHECK.
- CHECK: one accepted byte.
  - Byte equals the accumulator: go to DONE.
  - Byte differs: go to ERROR.
- Address: mem_addr = (BASE_ADDR + word index) mod RAM_SIZE. The arithmetic is done in 9 bits and then reduced, so the address wraps to 0 past RAM_SIZE-1.
- Words already written are not rolled back on ERROR.
- in_ready is high in COUNT, DATA and CHECK; it is low in IDLE, DONE and ERROR.
- cpu_hold = busy. It is also held high for the one cycle of a trailing mem_w pulse after leaving DATA.
- done and error are sticky until the next start or reset. They are never both high.
- in_valid while in_ready is low: the byte is ignored and has no effect.

## Timing
- Reset values: in_ready=0, mem_w=0, mem_addr=0, mem_w_word=0, cpu_hold=0, busy=0, done=0, error=0; state=IDLE.
- start is sampled on cycle t. The block enters COUNT and raises in_ready, busy and cpu_hold on t+1.
- Write latency: the 4th byte of a word is accepted on cycle t; mem_w, mem_addr and mem_w_word are registered and valid on t+1 for exactly one cycle.
- in_ready stays high during a mem_w cycle. The next byte may be accepted concurrently with the write.
- Throughput: one byte per cycle. A full load takes 4N+2 accepted bytes.
- The final word's mem_w pulse may coincide with the first CHECK cycle. The final checksum byte cannot arrive before that write has issued.
- DONE or ERROR is entered on the cycle after the deciding byte is accepted. done/error and busy=0 appear on that same cycle.
- start while busy: ignored; the load continues unaffected.
- reset mid-load: all outputs return to reset values asynchronously. A pending mem_w is dropped.

## Test plan
- Normal load, BASE_ADDR=0. Stimulus: start, then bytes 02, 00 04 00 2A, 00 01 00 00, 2D. Required: mem_w at addr 0 with 0x0004002A; mem_w at addr 1 with 0x00010000; done=1, error=0, cpu_hold=0 afterwards.
- Bad checksum. Stimulus: same stream with last byte 2C. Required: both writes still occur; error=1, done=0.
- Oversize count, RAM_SIZE=4. Stimulus: header 05. Required: error=1 on the next cycle, no mem_w, in_ready=0.
- Address wrap, RAM_SIZE=4, BASE_ADDR=3. Stimulus: 2 words. Required: writes to addr 3 and then addr 0.
- Backpressure and ignored start. Stimulus: in_valid toggled randomly and start pulsed during DATA. Required: words and checksum identical to the gap-free run. Bytes driven while in_ready is low are ignored.
- Reset mid-load. Stimulus: reset asserted after 6 bytes. Required: all outputs 0 immediately, no further mem_w; a new start then loads cleanly. Also N=0: stream 00, 00 gives done=1 with no writes.
